keypad_code_player: RTL and testbench
=====================================

Name: keypad_code_player

Overview:
- Replays a stored 8-digit BCD passcode as timed one-hot key presses on a 10-line keypad bus.
- It is the producing end of the keypad interface that input_encoder consumes. Its key bus connects directly to the encoder's 10-bit x input.
- Used for automated unlock/programming sequences, and as a reusable stimulus source in lock-level benches.
- One digit becomes one press pulse followed by a release gap, in order from digit 1 to digit 8.

Parameters:
- DIGITS, 8, number of BCD digits per code (code width = 4*DIGITS).
- PRESS_CYCLES, 4, clock cycles each key line is held high (min 1).
- GAP_CYCLES, 4, clock cycles all key lines are low after each press (min 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- start  input  1  request playback; sampled only in IDLE.
- abort  input  1  cancel playback in progress.
- code  input  4*DIGITS  passcode; digit 1 in bits [4*DIGITS-1 -: 4], digit DIGITS in [3:0]. This matches the {reg_out1..reg_out8} comparator ordering.
- key  output  10  one-hot keypad lines; key[d]=1 presses digit d.
- busy  output  1  high from the first PRESS cycle through the last GAP cycle.
- digit_idx  output  4  index (0..DIGITS-1) of the digit currently pressed or in its gap.
- done  output  1  one-cycle pulse after successful completion.
- err  output  1  one-cycle pulse when start is rejected for an invalid code.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; key=0, busy=0, digit_idx=0, done=0, err=0; internal code latch and counters cleared.
- Reset has priority over all other inputs. Reset asserted mid-playback forces all outputs to 0 on that edge, with no done or err pulse.
- States: IDLE, PRESS, GAP, FINISH.
- IDLE:
  - If start=1 and every digit of code is <=9: latch code, set digit_idx=0, go to PRESS.
  - If start=1 and any digit is >9: err=1 for one cycle, stay IDLE, and never drive key.
  - code is sampled only at the accepting edge; later changes to code are ignored.
- PRESS:
  - key = one-hot of latched digit[digit_idx]; busy=1.
  - Held exactly PRESS_CYCLES cycles, then go to GAP.
- GAP:
  - key=0; busy=1. Held exactly GAP_CYCLES cycles.
  - If digit_idx < DIGITS-1: increment digit_idx and go to PRESS.
  - Otherwise go to FINISH.
- FINISH: done=1, busy=0, key=0 for one cycle; digit_idx returns to 0; go to IDLE.
- Latency: the first key edge is registered one cycle after start is accepted. done occurs DIGITS*(PRESS_CYCLES+GAP_CYCLES)+1 cycles after the accepting edge.
- Invariants:
  - key is always 0 or exactly one bit high.
  - Two consecutive identical digits still produce two separate presses separated by a GAP. The encoder valid bit out[4] must fall between them.
- start while busy: ignored, with no queuing.
- start asserted in the FINISH cycle: ignored; a new start is accepted from the following IDLE cycle.
- abort=1 in PRESS or GAP: at the next edge key=0, busy=0, digit_idx=0, state=IDLE, no done.
- abort=1 in IDLE or FINISH: no effect (a FINISH done pulse still completes).
- Simultaneous start and abort in IDLE: abort wins, and the request is dropped.
- Counters: the cycle counter width is sized for max(PRESS_CYCLES, GAP_CYCLES). digit_idx saturates at DIGITS-1 and never wraps during a playback.

Test Plan:
- Basic playback, PRESS=GAP=4: reset, code=32'h21935488, pulse start.
  - key sequence is 10'b0000000100, 0000000010, 1000000000, 0000001000, 0000100000, 0000010000, 0100000000, then 0100000000 again.
  - Each press lasts 4 cycles with a 4-cycle zero gap between presses.
  - done pulses at cycle 65 after the accepting edge.
- Repeated digit: both trailing 8s appear as separate pulses; key=0 for exactly 4 cycles between them.
- Invalid code 32'h21A35488 + start: err=1 for one cycle, key stays 0, busy stays 0.
- Abort mid-run, asserted during digit_idx=3 PRESS: next edge key=0, busy=0, and done never pulses. A fresh start afterwards replays from digit 1.
- start retriggered while busy, and code changed mid-run: the output sequence is unchanged from the originally latched code, and only one done occurs.
- Synchronous reset (rst_n=0 for one edge) during GAP of digit 5: all outputs 0 at that edge; without a new start, key stays 0 afterwards.

Source files
------------

// File: rtl/keypad_code_player.sv
// Replays a latched BCD passcode as timed one-hot key presses on a 10-line keypad bus.
// Outputs are registered from the current state, so they trail the FSM by one edge.
module keypad_code_player #(
  parameter int DIGITS       = 8,
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4*DIGITS-1:0] code,
  output logic [9:0]          key,
  output logic                busy,
  output logic [3:0]          digit_idx,
  output logic                done,
  output logic                err
);

  localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, FINISH} state_t;

  state_t              state, state_n;
  logic [4*DIGITS-1:0] code_q, code_n;
  logic [3:0]          idx_q, idx_n, cur_digit;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic                code_ok, playing;
  logic [9:0]          key_n;
  logic [3:0]          didx_n;
  logic                busy_n, done_n, err_n;

  // A code is playable only if every nibble is a decimal digit.
  always_comb begin
    code_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (code[4*i +: 4] > 4'd9) code_ok = 1'b0;
  end

  // Digit 1 sits in the top nibble, so index i selects nibble DIGITS-1-i.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == 4'(i)) cur_digit = code_q[4*(DIGITS-1-i) +: 4];
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    code_n  = code_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        if (start && !abort && code_ok) begin
          code_n  = code;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = PRESS;
        end
      end
      PRESS: begin
        if (abort) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt_q == PRESS_LAST) begin
          cnt_n   = '0;
          state_n = GAP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          idx_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_n = '0;
          if (idx_q < IDX_LAST) begin
            idx_n   = idx_q + 1'b1;
            state_n = PRESS;
          end else begin
            state_n = FINISH;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        idx_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort clears the outputs on the same edge that returns the FSM to IDLE.
    playing = (state == PRESS || state == GAP) && !abort;
    key_n   = (state == PRESS && !abort) ? (10'd1 << cur_digit) : '0;
    busy_n  = playing;
    didx_n  = playing ? idx_q : '0;
    done_n  = (state == FINISH);
    err_n   = (state == IDLE) && start && !abort && !code_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      // NOTE: the code latch is a plain register, cleared on reset so a stale passcode never survives it.
      code_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      key       <= '0;
      busy      <= 1'b0;
      digit_idx <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      code_q    <= code_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      key       <= key_n;
      busy      <= busy_n;
      digit_idx <= didx_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_keypad_code_player.sv
// Randomized scoreboard bench for keypad_code_player: a timeline model predicts press,
// busy and pulse events; a negedge monitor reconstructs them from the pins and compares.
module tb_keypad_code_player;

  localparam int D = 8;
  localparam int P = 4;
  localparam int G = 4;
  localparam int T = P + G;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [4*D-1:0] code = '0;
  logic [9:0]     key;
  logic           busy;
  logic [3:0]     digit_idx;
  logic           done;
  logic           err;

  keypad_code_player #(.DIGITS(D), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .code(code),
    .key(key), .busy(busy), .digit_idx(digit_idx), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] val; int st; int len; int idx; } press_t;
  typedef struct { int st; int len; } busy_t;
  typedef struct { bit is_err; int cyc; } pulse_t;

  press_t press_q[$];
  busy_t  busy_q[$];
  pulse_t pulse_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int free_edge = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int digit_of(input logic [4*D-1:0] c, input int i);
    return int'(c[4*(D-1-i) +: 4]);
  endfunction

  function automatic bit code_valid(input logic [4*D-1:0] c);
    for (int i = 0; i < D; i++)
      if (digit_of(c, i) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4*D-1:0] rand_code(input bit bad);
    logic [4*D-1:0] c;
    int bi;
    c  = '0;
    bi = $urandom_range(0, D-1);
    for (int i = 0; i < D; i++)
      c[4*(D-1-i) +: 4] = (bad && i == bi) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return c;
  endfunction

  // Inputs are applied at a negedge and sampled by the following rising edge (cyc+1).
  task automatic step(input logic s, input logic a, input logic [4*D-1:0] c, input logic r);
    start = s;
    abort = a;
    code  = c;
    rst_n = r;
    @(negedge clk);
  endtask

  // One playback request. a = edge offset after acceptance where abort (or reset) is applied;
  // 0 means none, D*T+1 lands in the FINISH cycle where it must have no effect.
  task automatic play(input logic [4*D-1:0] c, input int a, input bit use_rst);
    int e, a_eff, bend;
    while (cyc + 1 < free_edge)
      step(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b1);
    e = cyc + 1;
    if (!code_valid(c)) begin
      pulse_q.push_back(pulse_t'{1'b1, e});
      free_edge = e + 1;
      step(1'b1, 1'b0, c, 1'b1);
      start = 1'b0;
      return;
    end
    a_eff = (a >= 1 && a <= D*T) ? a : 0;
    for (int i = 0; i < D; i++) begin
      int st;
      int len;
      st  = e + 1 + i*T;
      len = P;
      if (a_eff != 0 && e + a_eff - st < P) len = e + a_eff - st;
      if (len > 0) press_q.push_back(press_t'{10'(1 << digit_of(c, i)), st, len, i});
    end
    bend = (a_eff == 0) ? e + D*T + 1 : e + a_eff;
    if (bend > e + 1) busy_q.push_back(busy_t'{e + 1, bend - e - 1});
    if (a_eff == 0) pulse_q.push_back(pulse_t'{1'b0, e + D*T + 1});
    free_edge = (a_eff == 0) ? e + D*T + 2 : e + a_eff + 1;
    step(1'b1, 1'b0, c, 1'b1);
    for (int k = 1; k <= D*T + 1; k++) begin
      if (use_rst && k == a) step(1'b0, 1'b0, $urandom, 1'b0);
      else step(1'($urandom_range(0, 1)), (k == a), $urandom, 1'b1);
      if (a_eff != 0 && k == a_eff) break;
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask

  // Idle-time noise: start+abort together must be dropped, abort alone is harmless.
  task automatic idle_noise(input int n);
    for (int j = 0; j < n; j++) begin
      case ($urandom_range(0, 2))
        0:       step(1'b1, 1'b1, rand_code($urandom_range(0, 1) == 1), 1'b1);
        1:       step(1'b0, 1'b1, $urandom, 1'b1);
        default: step(1'b0, 1'b0, $urandom, 1'b1);
      endcase
    end
    abort = 1'b0;
  endtask

  // Monitor state
  logic [9:0] run_val = '0;
  int run_st = 0, run_len = 0, run_idx = 0;
  bit b_on = 1'b0;
  int b_st = 0, b_len = 0;

  task automatic end_press();
    press_t x;
    if (press_q.size() == 0) begin
      check("press_unexpected", 64'(run_val), 64'd0);
    end else begin
      x = press_q.pop_front();
      check("press_key", 64'(run_val), 64'(x.val));
      check("press_start", 64'(run_st), 64'(x.st));
      check("press_len", 64'(run_len), 64'(x.len));
      check("press_idx", 64'(run_idx), 64'(x.idx));
    end
  endtask

  task automatic end_busy();
    busy_t x;
    if (busy_q.size() == 0) begin
      check("busy_unexpected", 64'(b_len), 64'd0);
    end else begin
      x = busy_q.pop_front();
      check("busy_start", 64'(b_st), 64'(x.st));
      check("busy_len", 64'(b_len), 64'(x.len));
    end
  endtask

  task automatic pop_pulse(input bit is_err);
    pulse_t x;
    if (pulse_q.size() == 0) begin
      check(is_err ? "err_unexpected" : "done_unexpected", 64'd1, 64'd0);
    end else begin
      x = pulse_q.pop_front();
      check(is_err ? "err_kind" : "done_kind", 64'(is_err), 64'(x.is_err));
      check(is_err ? "err_cycle" : "done_cycle", 64'(cyc), 64'(x.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("key_onehot", 64'($countones(key) <= 1), 64'd1);
      if (key !== run_val) begin
        if (run_val != '0) end_press();
        run_val = key;
        run_st  = cyc;
        run_len = 0;
        run_idx = int'(digit_idx);
      end
      if (key != '0) run_len++;
      if (busy && !b_on) begin
        b_on  = 1'b1;
        b_st  = cyc;
        b_len = 0;
      end else if (!busy && b_on) begin
        b_on = 1'b0;
        end_busy();
      end
      if (busy) b_len++;
      if (done) pop_pulse(1'b0);
      if (err) pop_pulse(1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    repeat (2) @(negedge clk);
    check("rst_key", 64'(key), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_digit_idx", 64'(digit_idx), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    mon_en    = 1'b1;
    free_edge = cyc + 1;
    rst_n     = 1'b1;

    play(32'h21935488, 0, 1'b0);             // basic playback with repeated trailing 8s
    play(32'h21A35488, 0, 1'b0);             // invalid digit -> err only
    idle_noise(4);
    play(32'h21935488, 3*T + 2, 1'b0);       // abort during digit 4 press
    play(32'h21935488, 0, 1'b0);             // fresh replay from digit 1
    play(32'h21935488, 4*T + P + 2, 1'b1);   // reset during gap of digit 5
    idle_noise(12);
    play(32'h99000011, D*T + 1, 1'b0);       // abort in FINISH is ignored
    play(32'h55555555, 1, 1'b0);             // abort on the very first press cycle
    play(32'h76543210, D*T, 1'b0);           // abort in the last gap cycle

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    a = $urandom_range(1, D*T);
        3:          a = D*T + 1;
        default:    a = 0;
      endcase
      play(rand_code($urandom_range(0, 6) == 0), a, ($urandom_range(0, 7) == 0) && a >= 1 && a <= D*T);
      idle_noise($urandom_range(0, 3));
    end

    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    check("press_q_left", 64'(press_q.size()), 64'd0);
    check("busy_q_left", 64'(busy_q.size()), 64'd0);
    check("pulse_q_left", 64'(pulse_q.size()), 64'd0);
    check("final_key_idle", 64'(key), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
